// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V main control FSM; optional JALR support via RV_MC_JALR_EN
module multicycle_controller #(
    parameter int MEM_LAT_MAX = 15,
    parameter int ALUOP_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               stall,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               pc_write,
    output logic               ir_write,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic               Jump,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal,
    output logic               mem_timeout,
    output logic [2:0]         state
);

    localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
`ifdef RV_MC_JALR_EN
    localparam logic [6:0] OP_JALR = 7'b1100111;
`endif

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [6:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;

    logic               cnt_at_max;
    logic               waiting;
    logic               op_r, op_i, op_lw, op_sw, op_br, op_jal, op_jalr;

    logic               imem_req_c, dmem_req_c, pc_write_c, ir_write_c;
    logic               alusrc_c, memtoreg_c, regwrite_c, memread_c, memwrite_c;
    logic               branch_c, jump_c, timeout_c;
    logic [ALUOP_W-1:0] aluop_c;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL: is_legal = 1'b1;
`ifdef RV_MC_JALR_EN
            OP_JALR:                                 is_legal = 1'b1;
`endif
            default:                                 is_legal = 1'b0;
        endcase
    endfunction

    // Outputs decode only from the latched opcode, never from the live IR bits
    assign op_r   = (op_q == OP_R);
    assign op_i   = (op_q == OP_I);
    assign op_lw  = (op_q == OP_LW);
    assign op_sw  = (op_q == OP_SW);
    assign op_br  = (op_q == OP_BR);
    assign op_jal = (op_q == OP_JAL);
`ifdef RV_MC_JALR_EN
    assign op_jalr = (op_q == OP_JALR);
`else
    assign op_jalr = 1'b0;
`endif

    // This cycle is the MEM_LAT_MAX-th one spent waiting on a ready
    assign cnt_at_max = (cnt_q == CNT_W'(MEM_LAT_MAX - 1));

    // State, latched opcode, wait counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, wait-counter and Moore strobe decode
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        waiting    = 1'b0;
        timeout_c  = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        pc_write_c = 1'b0;
        ir_write_c = 1'b0;
        alusrc_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        branch_c   = 1'b0;
        jump_c     = 1'b0;
        aluop_c    = '0;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                // A stalled fetch is frozen: no load, no wait accounting
                if (!stall) begin
                    if (imem_ready) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        state_d    = S_DECODE;
                    end else if (cnt_at_max) begin
                        timeout_c = 1'b1;
                    end else begin
                        waiting = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (!stall) begin
                    if (is_legal(opcode)) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                alusrc_c = op_lw | op_sw | op_i | op_jalr;
                if (op_r | op_i) begin
                    aluop_c = ALUOP_W'(2'b10);
                end else if (op_br) begin
                    aluop_c = ALUOP_W'(2'b01);
                end
                if (!stall) begin
                    branch_c   = op_br;
                    jump_c     = op_jal | op_jalr;
                    regwrite_c = op_jal | op_jalr;
                    if (op_r | op_i) begin
                        state_d = S_WB;
                    end else if (op_lw | op_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                memread_c  = op_lw;
                memwrite_c = op_sw;
                alusrc_c   = 1'b1;
                if (dmem_ready) begin
                    state_d = op_lw ? S_WB : S_FETCH;
                end else if (cnt_at_max) begin
                    timeout_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WB: begin
                memtoreg_c = op_lw;
                if (!stall) begin
                    regwrite_c = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if ((state_d != state_q) || timeout_c) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Everything is forced low while reset is held
    assign imem_req    = rst_n & imem_req_c;
    assign dmem_req    = rst_n & dmem_req_c;
    assign pc_write    = rst_n & pc_write_c;
    assign ir_write    = rst_n & ir_write_c;
    assign ALUSrc      = rst_n & alusrc_c;
    assign MemtoReg    = rst_n & memtoreg_c;
    assign RegWrite    = rst_n & regwrite_c;
    assign MemRead     = rst_n & memread_c;
    assign MemWrite    = rst_n & memwrite_c;
    assign Branch      = rst_n & branch_c;
    assign Jump        = rst_n & jump_c;
    assign ALUOp       = {ALUOP_W{rst_n}} & aluop_c;
    assign illegal     = rst_n & illegal_q;
    assign mem_timeout = rst_n & timeout_c;
    assign state       = rst_n ? state_q : 3'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam int MAX = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n, stall;
    logic [6:0] opcode;
    logic       imem_ready, dmem_ready;
    logic       imem_req, dmem_req, pc_write, ir_write;
    logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
    logic [1:0] ALUOp;
    logic       illegal, mem_timeout;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    int i_delay = 0;
    int d_delay = 0;
    int icnt = 0;
    int dcnt = 0;

    multicycle_controller #(.MEM_LAT_MAX(MAX), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall(stall),
        .imem_req(imem_req), .dmem_req(dmem_req), .pc_write(pc_write), .ir_write(ir_write),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .ALUOp(ALUOp),
        .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    // Memory models: ready comes after a programmed number of requesting cycles
    assign imem_ready = imem_req && (icnt >= i_delay);
    assign dmem_ready = dmem_req && (dcnt >= d_delay);

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    end

    logic [13:0] other_outs;
    assign other_outs = {imem_req, dmem_req, pc_write, ir_write, ALUSrc, MemtoReg, RegWrite,
                         MemRead, MemWrite, Branch, Jump, ALUOp, mem_timeout};

    typedef struct packed {
        int cycles; int pcw; int irw; int regw; int m2r; int mrd; int mwr;
        int br; int jmp; int tmo; int aluop; int alusrc; int overlap;
    } res_t;

    typedef struct packed {
        logic [6:0] op; int di; int dd;
        int cycles; int regw; int memop; int tmo; int aluop;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Per-instruction totals derived from the cycle budget of each instruction class
    function automatic res_t model(input logic [6:0] op, input int di, input int dd);
        res_t e;
        int   mem;
        bit   ok;
        e = '0;
        ok = (dd < MAX);
        mem = ok ? dd + 1 : MAX;
        e.pcw = 1;
        e.irw = 1;
        e.cycles = (di + 1) + 1 + 1;
        case (op)
            OP_R:   begin e.cycles += 1; e.regw = 1; e.aluop = 2; end
            OP_I:   begin e.cycles += 1; e.regw = 1; e.aluop = 2; e.alusrc = 1; end
            OP_LW:  begin
                e.alusrc = 1; e.cycles += mem; e.mrd = mem;
                if (ok) begin e.cycles += 1; e.regw = 1; e.m2r = 1; end
                else e.tmo = 1;
            end
            OP_SW:  begin
                e.alusrc = 1; e.cycles += mem; e.mwr = mem;
                if (!ok) e.tmo = 1;
            end
            OP_BR:  begin e.br = 1; e.aluop = 1; end
            default: begin e.jmp = 1; e.regw = 1; end
        endcase
        return e;
    endfunction

    // Runs one instruction from its FETCH cycle until the next FETCH, tallying strobes
    task automatic run_instr(input logic [6:0] op, input int di, input int dd, output res_t o);
        bit left = 0;
        bit done = 0;
        o = '0;
        opcode = op; i_delay = di; d_delay = dd; stall = 1'b0;
        #1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (state == 3'd0 && left) begin
                done = 1;
            end else begin
                if (state != 3'd0) left = 1;
                o.cycles += 1;
                o.pcw    += int'(pc_write);
                o.irw    += int'(ir_write);
                o.regw   += int'(RegWrite);
                o.m2r    += int'(MemtoReg);
                o.mrd    += int'(MemRead);
                o.mwr    += int'(MemWrite);
                o.br     += int'(Branch);
                o.jmp    += int'(Jump);
                o.tmo    += int'(mem_timeout);
                o.overlap += int'(MemWrite & RegWrite);
                if (state == 3'd2) begin
                    o.aluop  = int'(ALUOp);
                    o.alusrc = int'(ALUSrc);
                end
                nxt();
            end
        end
        check($sformatf("instr %b completes", op), int'(done), 1);
    endtask

    task automatic cmp(input string tag, input res_t o, input res_t e);
        check({tag, " cycles"},   o.cycles,  e.cycles);
        check({tag, " pc_write"}, o.pcw,     e.pcw);
        check({tag, " ir_write"}, o.irw,     e.irw);
        check({tag, " RegWrite"}, o.regw,    e.regw);
        check({tag, " MemtoReg"}, o.m2r,     e.m2r);
        check({tag, " MemRead"},  o.mrd,     e.mrd);
        check({tag, " MemWrite"}, o.mwr,     e.mwr);
        check({tag, " Branch"},   o.br,      e.br);
        check({tag, " Jump"},     o.jmp,     e.jmp);
        check({tag, " timeout"},  o.tmo,     e.tmo);
        check({tag, " ALUOp"},    o.aluop,   e.aluop);
        check({tag, " ALUSrc"},   o.alusrc,  e.alusrc);
        check({tag, " overlap"},  o.overlap, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        res_t        o, e;
        logic [6:0]  ops[6];
        int          exp_st[5];
        int          exp_rw[5];
        bit          seen;

        vecs[0] = '{OP_R,   0, 0,  4, 1, 0, 0, 2};
        vecs[1] = '{OP_I,   3, 0,  7, 1, 0, 0, 2};
        vecs[2] = '{OP_LW,  0, 3,  8, 1, 4, 0, 0};
        vecs[3] = '{OP_LW,  0, 0,  5, 1, 1, 0, 0};
        vecs[4] = '{OP_LW,  0, 4,  7, 0, 4, 1, 0};
        vecs[5] = '{OP_SW,  0, 0,  4, 0, 1, 0, 0};
        vecs[6] = '{OP_SW,  0, 99, 7, 0, 4, 1, 0};
        vecs[7] = '{OP_BR,  2, 0,  5, 0, 0, 0, 1};
        vecs[8] = '{OP_JAL, 0, 0,  3, 1, 0, 0, 0};
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL};
        exp_st = '{0, 1, 2, 4, 0};
        exp_rw = '{0, 0, 0, 1, 0};

        // Reset: all outputs gated low, then FETCH requesting
        rst_n = 1'b0; stall = 1'b0; opcode = '0;
        @(negedge clk); @(negedge clk); #1;
        check("reset outs", int'(other_outs), 0);
        check("reset state", int'(state), 0);
        check("reset illegal", int'(illegal), 0);
        rst_n = 1'b1;
        #1;
        check("post-reset state", int'(state), 0);
        check("post-reset imem_req", int'(imem_req), 1);

        // ADD with zero-latency memories walks FETCH, DECODE, EXEC, WB
        opcode = OP_R; i_delay = 0; d_delay = 0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("add state[%0d]", k), int'(state), exp_st[k]);
            check($sformatf("add RegWrite[%0d]", k), int'(RegWrite), exp_rw[k]);
            if (k == 2) check("add ALUOp exec", int'(ALUOp), 2);
            if (k < 4) nxt();
        end

        // Directed vector table
        foreach (vecs[v]) begin
            run_instr(vecs[v].op, vecs[v].di, vecs[v].dd, o);
            check($sformatf("vec%0d cycles", v),   o.cycles,        vecs[v].cycles);
            check($sformatf("vec%0d RegWrite", v), o.regw,          vecs[v].regw);
            check($sformatf("vec%0d memop", v),    o.mrd + o.mwr,   vecs[v].memop);
            check($sformatf("vec%0d timeout", v),  o.tmo,           vecs[v].tmo);
            check($sformatf("vec%0d ALUOp", v),    o.aluop,         vecs[v].aluop);
            check($sformatf("vec%0d overlap", v),  o.overlap,       0);
        end

        // Branch stalled for three EXEC cycles
        opcode = OP_BR; i_delay = 0; d_delay = 0;
        #1;
        check("beq fetch", int'(state), 0);
        nxt();
        check("beq decode", int'(state), 1);
        @(posedge clk); #1;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check($sformatf("beq stalled state[%0d]", k), int'(state), 2);
            check($sformatf("beq stalled Branch[%0d]", k), int'(Branch), 0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        nxt();
        check("beq exec state", int'(state), 2);
        check("beq Branch", int'(Branch), 1);
        nxt();
        check("beq back to fetch", int'(state), 0);
        check("beq Branch after", int'(Branch), 0);

        // Instruction fetch that never answers times out after MAX cycles
        opcode = OP_R; i_delay = 99;
        #1;
        for (int k = 1; k <= MAX; k++) begin
            check($sformatf("ifetch timeout[%0d]", k), int'(mem_timeout), int'(k == MAX));
            check($sformatf("ifetch state[%0d]", k), int'(state), 0);
            nxt();
        end
        check("ifetch after timeout state", int'(state), 0);
        check("ifetch after timeout pulse", int'(mem_timeout), 0);
        run_instr(OP_R, 0, 0, o);
        cmp("refetch", o, model(OP_R, 0, 0));

        // Randomized instructions against the transaction-level model
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            int di, dd;
            op = ops[$urandom_range(0, 5)];
            di = $urandom_range(0, MAX - 1);
            dd = $urandom_range(0, MAX + 1);
            e = model(op, di, dd);
            run_instr(op, di, dd, o);
            cmp($sformatf("rnd%0d op=%b di=%0d dd=%0d", n, op, di, dd), o, e);
        end

        // Reset in the middle of a load aborts it
        opcode = OP_LW; i_delay = 0; d_delay = 99;
        #1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (state == 3'd3) seen = 1;
            else nxt();
        end
        check("lw reached MEM", int'(seen), 1);
        nxt();
        rst_n = 1'b0;
        #1;
        check("mid-reset outs", int'(other_outs), 0);
        check("mid-reset state", int'(state), 0);
        nxt();
        rst_n = 1'b1;
        #1;
        check("after abort state", int'(state), 0);
        check("after abort MemRead", int'(MemRead), 0);
        check("after abort dmem_req", int'(dmem_req), 0);
        check("after abort imem_req", int'(imem_req), 1);

        // JALR: legal jump-and-link when enabled, otherwise trapped
        opcode = OP_JALR; i_delay = 0; d_delay = 0;
        #1;
        nxt();
        nxt();
`ifdef RV_MC_JALR_EN
        check("jalr exec state", int'(state), 2);
        check("jalr Jump", int'(Jump), 1);
        check("jalr RegWrite", int'(RegWrite), 1);
        check("jalr ALUSrc", int'(ALUSrc), 1);
        check("jalr ALUOp", int'(ALUOp), 0);
        nxt();
        check("jalr back to fetch", int'(state), 0);
`else
        check("jalr trap state", int'(state), 5);
        check("jalr illegal", int'(illegal), 1);
        check("jalr trap outs", int'(other_outs), 0);
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        #1;
        check("jalr reset state", int'(state), 0);
`endif

        // Illegal opcode traps and sticks until reset
        opcode = OP_BAD; i_delay = 0;
        #1;
        nxt();
        check("bad decode state", int'(state), 1);
        check("bad decode illegal", int'(illegal), 0);
        for (int k = 0; k < 3; k++) begin
            nxt();
            check($sformatf("trap state[%0d]", k), int'(state), 5);
            check($sformatf("trap illegal[%0d]", k), int'(illegal), 1);
            check($sformatf("trap outs[%0d]", k), int'(other_outs), 0);
        end
        rst_n = 1'b0;
        #1;
        check("trap reset illegal gated", int'(illegal), 0);
        nxt();
        rst_n = 1'b1;
        #1;
        check("trap cleared state", int'(state), 0);
        check("trap cleared illegal", int'(illegal), 0);
        check("trap cleared imem_req", int'(imem_req), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
